axi4_sram_slave: RTL
====================

AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

Interface
REQ-001 Parameter DATA_W, default DATA_BUS_WIDTH, data bus width in bits (power of 2, >=32).
REQ-002 Parameter ID_W, default ID_BUS_WIDTH_M, AXI ID width.
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, first byte address served.
REQ-004 Parameter DEPTH, default 1024, number of DATA_W-bit words; served window = BASE_ADDR .. BASE_ADDR+DEPTH*DATA_W/8-1.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 axi_req_i  input  axi_req_t  AXI4 AW/W/AR channels plus bready/rready from the master.
REQ-008 axi_resp_o  output  axi_resp_t  AXI4 awready/wready/arready plus B and R channels to the master.

Function
REQ-009 Write path and read path SHALL be independent FSMs; one outstanding burst per direction; no reordering.
REQ-010 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
REQ-011 W_IDLE: on awvalid&awready, capture awid, awaddr aligned down to awsize, awlen, awsize, awburst; go to W_DATA next cycle.
REQ-012 W_DATA: each wvalid&wready beat writes wstrb-enabled bytes to the current word if in window; out-of-window beats are discarded and set the error flag to DECERR.
REQ-013 Beat address: INCR adds 1<<awsize per beat; FIXED holds the address; WRAP is treated as INCR and sets the error flag to SLVERR.
REQ-014 Burst ends on beat count == awlen; wlast asserted early or missing on the final beat sets SLVERR; W_DATA -> W_RESP after the final beat regardless of wlast.
REQ-015 W_RESP: bid = captured id, bresp = worst flag (DECERR > SLVERR > OKAY); bvalid held until bready; then W_IDLE and the flag clears.
REQ-016 Read FSM states: R_IDLE (arready=1), R_DATA (rvalid=1).
REQ-017 R_IDLE: on arvalid&arready, capture AR fields as in REQ-011; rvalid rises exactly one cycle later with beat 0 data.
REQ-018 rdata is a registered memory output, reloaded on each rvalid&rready that is not last; rdata/rresp/rlast/rid SHALL stay stable while rvalid&!rready.
REQ-019 rlast=1 only on beat awlen-equivalent (arlen); rvalid&rready&rlast -> R_IDLE; arready is low during R_DATA.
REQ-020 Out-of-window read beat: rdata=0, rresp=DECERR; other beats OKAY; WRAP burst returns SLVERR on every beat with valid data.
REQ-021 awsize/arsize larger than log2(DATA_W/8): whole burst handled with SLVERR, no memory write.
REQ-022 Same-cycle read load and write to the same word: read returns the old data (read-first).
REQ-023 4 KB boundary crossings are not checked; addresses wrap modulo 2^32.

Reset
REQ-024 While rst=1: both FSMs idle, awready=arready=wready=bvalid=rvalid=0, rlast=0, bresp=rresp=OKAY, rdata=0, error flags cleared.
REQ-025 awready and arready rise on the first clock edge after rst deasserts.
REQ-026 Memory contents are not reset.
REQ-027 rst asserted mid-burst aborts the burst immediately; no B or R response is issued for it afterward.

Verification (DATA_W=32, DEPTH=1024)
REQ-028 AW 0x8000_0100 len=3 size=2 INCR, W 0x11..,0x22..,0x33..,0x44.. strb=F, last on beat 3 -> B OKAY; AR same -> 4 beats identical data, rlast only on beat 3, first rvalid 1 cycle after AR handshake.
REQ-029 Write 0xAABBCCDD strb=4'b0101 over 0xFFFF_FFFF at 0x8000_0200 -> read returns 0xFFBBFFDD.
REQ-030 AR 0x8000_0FFC len=1 -> beat 0 OKAY with stored data, beat 1 (0x8000_1000) rdata=0 DECERR; write there -> bresp DECERR, memory unchanged.
REQ-031 Read len=7 with rready toggling 1,0,0,1 -> every beat delivered once, in order, stable while stalled; concurrent write burst elsewhere completes with B OKAY.
REQ-032 Write len=3 with wlast on beat 1 -> 4 beats consumed, bresp SLVERR; AR with arsize=3 -> SLVERR.
REQ-033 Assert rst during beat 2 of a len=7 read -> rvalid=0 immediately, arready=1 one edge after release, no stray R beats.

Source files
------------

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a word-addressed SRAM with independent read and write burst engines.
// Responses grade as DECERR > SLVERR > OKAY; reads load a registered memory output per beat.
package axi4_sram_pkg;
    localparam int DATA_BUS_WIDTH = 32;
    localparam int ID_BUS_WIDTH_M = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [ID_BUS_WIDTH_M-1:0]   awid;
        logic [31:0]                 awaddr;
        logic [7:0]                  awlen;
        logic [2:0]                  awsize;
        logic [1:0]                  awburst;
        logic                        awvalid;
        logic [DATA_BUS_WIDTH-1:0]   wdata;
        logic [DATA_BUS_WIDTH/8-1:0] wstrb;
        logic                        wlast;
        logic                        wvalid;
        logic                        bready;
        logic [ID_BUS_WIDTH_M-1:0]   arid;
        logic [31:0]                 araddr;
        logic [7:0]                  arlen;
        logic [2:0]                  arsize;
        logic [1:0]                  arburst;
        logic                        arvalid;
        logic                        rready;
    } axi_req_t;

    typedef struct packed {
        logic                        awready;
        logic                        wready;
        logic                        arready;
        logic [ID_BUS_WIDTH_M-1:0]   bid;
        logic [1:0]                  bresp;
        logic                        bvalid;
        logic [ID_BUS_WIDTH_M-1:0]   rid;
        logic [DATA_BUS_WIDTH-1:0]   rdata;
        logic [1:0]                  rresp;
        logic                        rlast;
        logic                        rvalid;
    } axi_resp_t;
endpackage

module axi4_sram_slave
    import axi4_sram_pkg::*;
#(
    parameter int          DATA_W    = DATA_BUS_WIDTH,
    parameter int          ID_W      = ID_BUS_WIDTH_M,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic      clk,
    input  logic      rst,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o
);
    localparam int          BYTES     = DATA_W / 8;
    localparam int          ADDR_LSB  = $clog2(BYTES);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * BYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    function automatic logic [31:0] align(input logic [31:0] a, input logic [2:0] s);
        return a & ~((32'd1 << s) - 32'd1);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] s,
                                              input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + (32'd1 << s);
    endfunction

    function automatic logic in_win(input logic [31:0] a);
        return (a - BASE_ADDR) < WIN_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> ADDR_LSB);
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Ready outputs stay low until the first edge after reset release.
    logic r_live;

    // ---------------- write path ----------------
    wstate_t          r_wstate, w_wnext;
    logic [ID_W-1:0]  r_wid;
    logic [31:0]      r_waddr;
    logic [7:0]       r_wlen, r_wcnt;
    logic [2:0]       r_wsize;
    logic [1:0]       r_wburst, r_werr, w_wbeat_err;
    logic             w_awready, w_wready, w_bvalid, w_aw_fire, w_w_fire;
    logic             w_wlast_beat, w_wsize_bad, w_aw_bad, w_mem_we;

    assign w_awready    = r_live && (r_wstate == W_IDLE);
    assign w_wready     = (r_wstate == W_DATA);
    assign w_bvalid     = (r_wstate == W_RESP);
    assign w_aw_fire    = axi_req_i.awvalid && w_awready;
    assign w_w_fire     = axi_req_i.wvalid && w_wready;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_wsize_bad  = (r_wsize > 3'(ADDR_LSB));
    assign w_aw_bad     = (axi_req_i.awburst == BURST_WRAP) || (axi_req_i.awsize > 3'(ADDR_LSB));
    assign w_mem_we     = w_w_fire && in_win(r_waddr) && !w_wsize_bad;

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_fire)                  w_wnext = W_DATA;
            W_DATA:  if (w_w_fire && w_wlast_beat)   w_wnext = W_RESP;
            W_RESP:  if (axi_req_i.bready)           w_wnext = W_IDLE;
            default:                                 w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        w_wbeat_err = r_werr;
        if (!in_win(r_waddr))
            w_wbeat_err = RESP_DECERR;
        else if (axi_req_i.wlast != w_wlast_beat)
            w_wbeat_err = worst(r_werr, RESP_SLVERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live   <= 1'b0;
            r_wstate <= W_IDLE;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_werr   <= RESP_OKAY;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wnext;
            if (w_aw_fire) begin
                r_wid    <= axi_req_i.awid;
                r_waddr  <= align(axi_req_i.awaddr, axi_req_i.awsize);
                r_wlen   <= axi_req_i.awlen;
                r_wsize  <= axi_req_i.awsize;
                r_wburst <= axi_req_i.awburst;
                r_wcnt   <= '0;
                r_werr   <= w_aw_bad ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_w_fire) begin
                r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
                r_wcnt  <= r_wcnt + 8'd1;
                r_werr  <= w_wbeat_err;
            end
            if (w_bvalid && axi_req_i.bready)
                r_werr <= RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (axi_req_i.wstrb[b])
                    r_mem[word_idx(r_waddr)][8*b +: 8] <= axi_req_i.wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t           r_rstate, w_rnext;
    logic [ID_W-1:0]   r_rid;
    logic [31:0]       r_raddr, w_ld_addr;
    logic [7:0]        r_rlen, r_rcnt;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst, r_rresp, w_ld_resp;
    logic              r_rwrap, r_rover, w_ld_wrap, w_ld_over;
    logic [DATA_W-1:0] r_rdata, w_ld_data;
    logic              w_arready, w_rvalid, w_rlast, w_ar_fire, w_r_fire, w_rload;

    assign w_arready = r_live && (r_rstate == R_IDLE);
    assign w_rvalid  = (r_rstate == R_DATA);
    assign w_rlast   = w_rvalid && (r_rcnt == r_rlen);
    assign w_ar_fire = axi_req_i.arvalid && w_arready;
    assign w_r_fire  = w_rvalid && axi_req_i.rready;
    assign w_rload   = w_ar_fire || (w_r_fire && !w_rlast);

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_fire)            w_rnext = R_DATA;
            R_DATA:  if (w_r_fire && w_rlast)  w_rnext = R_IDLE;
            default:                           w_rnext = R_IDLE;
        endcase
    end

    // Memory data is fetched the cycle before it is presented, so a write in the same cycle is not seen.
    always_comb begin
        w_ld_addr = w_ar_fire ? align(axi_req_i.araddr, axi_req_i.arsize)
                              : next_addr(r_raddr, r_rsize, r_rburst);
        w_ld_over = w_ar_fire ? (axi_req_i.arsize > 3'(ADDR_LSB)) : r_rover;
        w_ld_wrap = w_ar_fire ? (axi_req_i.arburst == BURST_WRAP) : r_rwrap;
        w_ld_data = '0;
        w_ld_resp = RESP_OKAY;
        if (!in_win(w_ld_addr)) begin
            w_ld_resp = RESP_DECERR;
        end else if (w_ld_over) begin
            w_ld_resp = RESP_SLVERR;
        end else begin
            w_ld_data = r_mem[word_idx(w_ld_addr)];
            if (w_ld_wrap)
                w_ld_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rwrap  <= 1'b0;
            r_rover  <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rnext;
            if (w_ar_fire) begin
                r_rid    <= axi_req_i.arid;
                r_rlen   <= axi_req_i.arlen;
                r_rsize  <= axi_req_i.arsize;
                r_rburst <= axi_req_i.arburst;
                r_rwrap  <= w_ld_wrap;
                r_rover  <= w_ld_over;
                r_rcnt   <= '0;
            end else if (w_r_fire && !w_rlast) begin
                r_rcnt <= r_rcnt + 8'd1;
            end
            if (w_rload) begin
                r_raddr <= w_ld_addr;
                r_rdata <= w_ld_data;
                r_rresp <= w_ld_resp;
            end
        end
    end

    always_comb begin
        axi_resp_o         = '0;
        axi_resp_o.awready = w_awready;
        axi_resp_o.wready  = w_wready;
        axi_resp_o.arready = w_arready;
        axi_resp_o.bid     = r_wid;
        axi_resp_o.bresp   = r_werr;
        axi_resp_o.bvalid  = w_bvalid;
        axi_resp_o.rid     = r_rid;
        axi_resp_o.rdata   = r_rdata;
        axi_resp_o.rresp   = r_rresp;
        axi_resp_o.rlast   = w_rlast;
        axi_resp_o.rvalid  = w_rvalid;
    end
endmodule
